fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 32-bit MIPS datapath. It holds the PC, drives the instruction-memory address, and applies branch/jump redirects, stalls and flushes. It registers the fetched word and PC+4 for the decode stage. The low halfword of the registered instruction is the 16-bit immediate consumed by the decode-stage sign extender.

---
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register with jump/branch/stall selection
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [XLEN-1:0] BUBBLE = XLEN'(0);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  // Modulo-2^32 increment; wraps from FFFF_FFFC to 0 with no flag.
  assign pc_plus4 = pc + XLEN'(PC_STEP);
  assign redirect = jump | branch_taken;
  assign imem_addr = pc;

  // Jump beats branch, any redirect beats stall; targets are forced word-aligned.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {jump_target[XLEN-1:2], 2'b00};
    end else if (branch_taken) begin
      next_pc = {branch_target[XLEN-1:2], 2'b00};
    end else if (stall) begin
      next_pc = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // The word fetched during a redirect is on the wrong path, so it becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr <= BUBBLE;
      if_id_pc4   <= BUBBLE;
      if_id_valid <= 1'b0;
    end else if (redirect || flush) begin
      if_id_instr <= BUBBLE;
      if_id_pc4   <= BUBBLE;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= imem_rdata;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for wrap and
// async reset, then random control traffic against a behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;

  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;
  logic        w_valid;

  int total = 0;
  int bad   = 0;

  // Memory image: the word at byte address a is 0x1000_0000 + a/4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .if_id_instr(w_instr), .if_id_pc4(w_pc4), .if_id_valid(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic s, input logic f, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
    stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_ctl(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s, f, b, j;
    logic [31:0] bt, jt;
    logic [31:0] pc, instr, pc4;
    logic        valid;
  } vec_t;

  vec_t vec[16];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  // Model of one rising edge, straight from the fetch rules.
  task automatic model_edge();
    logic [31:0] npc;
    if (jump)              npc = jump_target & 32'hFFFF_FFFC;
    else if (branch_taken) npc = branch_target & 32'hFFFF_FFFC;
    else if (stall)        npc = m_pc;
    else                   npc = m_pc + 32'd4;
    if (jump || branch_taken || flush) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    m_pc = npc;
  endtask

  initial begin
    //          s  f  b  j  bt             jt             pc             instr          pc4            v
    vec[0]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1};
    vec[1]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1};
    vec[2]  = '{0, 0, 1, 0, 32'h0000_0040, 32'h0,         32'h0000_0040, 32'h0,         32'h0,         0};
    vec[3]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0044, 32'h1000_0010, 32'h0000_0044, 1};
    vec[4]  = '{0, 0, 1, 1, 32'h0000_0200, 32'h0000_0103, 32'h0000_0100, 32'h0,         32'h0,         0};
    vec[5]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0104, 32'h1000_0040, 32'h0000_0104, 1};
    vec[6]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0108, 32'h1000_0041, 32'h0000_0108, 1};
    vec[7]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0108, 32'h1000_0041, 32'h0000_0108, 1};
    vec[8]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0108, 32'h1000_0041, 32'h0000_0108, 1};
    vec[9]  = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0108, 32'h1000_0041, 32'h0000_0108, 1};
    vec[10] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_010C, 32'h1000_0042, 32'h0000_010C, 1};
    vec[11] = '{1, 1, 0, 0, 32'h0,         32'h0,         32'h0000_010C, 32'h0,         32'h0,         0};
    vec[12] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0110, 32'h1000_0043, 32'h0000_0110, 1};
    vec[13] = '{1, 0, 1, 0, 32'h0000_0021, 32'h0,         32'h0000_0020, 32'h0,         32'h0,         0};
    vec[14] = '{0, 1, 0, 0, 32'h0,         32'h0,         32'h0000_0024, 32'h0,         32'h0,         0};
    vec[15] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0028, 32'h1000_0009, 32'h0000_0028, 1};

    // Async reset assertion without any clock edge
    rst_n = 1'b1;
    set_ctl(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFF8);
    cyc();
    cyc();
    chk("rst_hold_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      set_ctl(vec[i].s, vec[i].f, vec[i].b, vec[i].bt, vec[i].j, vec[i].jt);
      cyc();
      chk($sformatf("vec%0d_pc", i),    imem_addr,   vec[i].pc);
      chk($sformatf("vec%0d_instr", i), if_id_instr, vec[i].instr);
      chk($sformatf("vec%0d_pc4", i),   if_id_pc4,   vec[i].pc4);
      chk($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(vec[i].valid));
    end

    // Wrap-around on the high-reset-PC instance
    do_reset();
    cyc();
    chk("wrap1_pc",    w_addr,  32'hFFFF_FFFC);
    chk("wrap1_instr", w_instr, 32'h4FFF_FFFE);
    chk("wrap1_pc4",   w_pc4,   32'hFFFF_FFFC);
    cyc();
    chk("wrap2_pc",    w_addr,  32'h0000_0000);
    chk("wrap2_pc4",   w_pc4,   32'h0000_0000);
    chk("wrap2_valid", 32'(w_valid), 32'h1);
    cyc();
    chk("wrap3_pc",    w_addr,  32'h0000_0004);
    chk("wrap3_instr", w_instr, 32'h1000_0000);

    // Random control traffic against the model
    do_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      set_ctl(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), $urandom,
              ($urandom_range(0, 11) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        branch_target = 32'($urandom_range(0, 255));
        jump_target   = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end
      model_edge();
      cyc();
      chk("rnd_pc",    imem_addr,   m_pc);
      chk("rnd_instr", if_id_instr, m_instr);
      chk("rnd_pc4",   if_id_pc4,   m_pc4);
      chk("rnd_valid", 32'(if_id_valid), 32'(m_valid));
    end

    // Mid-operation reset between edges clears state immediately
    set_ctl(0, 0, 0, 0, 0, 0);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_addr",  imem_addr, 32'h0);
    chk("async_instr", if_id_instr, 32'h0);
    chk("async_pc4",   if_id_pc4, 32'h0);
    chk("async_valid", 32'(if_id_valid), 32'h0);
    chk("async_waddr", w_addr, 32'hFFFF_FFF8);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_instr", if_id_instr, 32'h1000_0000);
    chk("rel_pc",    imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
